mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, byte address of TXDATA register.
REQ-002 SHALL have parameter CLK_DIV, default 868, clk cycles per UART bit, legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two, legal range 2..64.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_io_write_addr  input  32  core data-bus write address.
REQ-007 SHALL have port i_io_write_en  input  1  core data-bus write strobe, one cycle per store.
REQ-008 SHALL have port i_io_write_data  input  32  core data-bus write data.
REQ-009 SHALL have port o_tx  output  1  UART serial line, idle high.
REQ-010 SHALL have port o_busy  output  1  high while FIFO is non-empty or a frame is in flight.
REQ-011 SHALL have port o_fifo_full  output  1  high when the FIFO holds FIFO_DEPTH bytes.
REQ-012 SHALL have port o_overflow  output  1  sticky flag: a TXDATA write was dropped.

Function
REQ-013 Write with addr == BASE_ADDR (TXDATA) SHALL push i_io_write_data[7:0] into the FIFO; bits [31:8] ignored.
REQ-014 Write with addr == BASE_ADDR+4 (CTRL) and data[0]=1 SHALL clear o_overflow on the next edge; all other CTRL bits ignored.
REQ-015 Writes to any other address SHALL be ignored.
REQ-016 TXDATA write while full with no pop in the same cycle SHALL be dropped and SHALL set o_overflow.
REQ-017 TXDATA write while full with a pop in the same cycle SHALL be accepted; count unchanged, o_overflow unchanged.
REQ-018 Overflow set and CTRL clear in the same cycle are mutually exclusive by address; set SHALL win if both occur across consecutive cycles in order.
REQ-019 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-020 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-021 IDLE: o_tx=1; if FIFO non-empty, pop head into 8-bit shift register and go to START next cycle.
REQ-022 START: o_tx=0 for exactly CLK_DIV cycles, then DATA.
REQ-023 DATA: 8 bits LSB first, each held exactly CLK_DIV cycles, bit counter 0..7, then STOP.
REQ-024 STOP: o_tx=1 for exactly CLK_DIV cycles, then IDLE.
REQ-025 Baud counter SHALL load CLK_DIV-1 on every state entry and bit boundary, decrement to 0, width $clog2(CLK_DIV).
REQ-026 o_tx SHALL be driven from a flop (glitch-free).
REQ-027 Latency: TXDATA write sampled at edge N into empty idle block SHALL give o_tx falling at edge N+2.
REQ-028 Back-to-back bytes SHALL have frame period exactly 10*CLK_DIV+1 cycles (one IDLE cycle between frames).
REQ-029 o_busy SHALL be combinational: (state != IDLE) or (count != 0).

Reset
REQ-030 While rstn=0: state=IDLE, o_tx=1, FIFO count and pointers 0, o_overflow=0, o_busy=0, o_fifo_full=0, counters 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately (o_tx=1 asynchronously) and discard FIFO contents.
REQ-032 First write after rstn deassertion SHALL be accepted on the first rising edge with rstn=1.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum (uart_tx_state_t) and register offsets TXDATA_OFS=0, CTRL_OFS=4.
REQ-034 FIFO SHALL be a sub-module sync_fifo (params WIDTH, DEPTH; ports clk, rstn, push, pop, wdata, rdata, full, empty, count).
REQ-035 Address decode, FSM, baud counter and shift register SHALL live in mmio_uart_tx.

Verification (CLK_DIV=4, FIFO_DEPTH=8, BASE_ADDR=32'h1000)
REQ-036 Write 0x1000 <- 0x55 -> o_tx low at N+2, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; o_busy low afterwards.
REQ-037 Write 0x1000 <- 0xFFFFFF41 -> serialized byte 0x41 only.
REQ-038 Ten consecutive TXDATA writes 0x00..0x09 while idle -> bytes 0x00..0x08 transmitted (one popped before full), 0x09 dropped, o_overflow=1; frame period 41 cycles.
REQ-039 Write 0x1004 <- 0x1 after overflow -> o_overflow=0 next cycle; write 0x1008 -> no effect.
REQ-040 Fill FIFO, write TXDATA in the IDLE-pop cycle -> accepted, o_overflow stays 0.
REQ-041 Assert rstn=0 during DATA bit 3 -> o_tx=1 immediately, o_busy=0, no further frames after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] CTRL_OFS   = 32'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and occupancy count.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when a pop frees the slot.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART 8N1 transmitter behind a two-register MMIO window (TXDATA, CTRL).
// o_tx is registered from the current state, so it trails the FSM by one cycle.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_io_write_addr,
    input  logic        i_io_write_en,
    input  logic [31:0] i_io_write_data,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_fifo_full,
    output logic        o_overflow
);

    localparam int CW  = $clog2(CLK_DIV);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLK_DIV - 1);

    uart_tx_state_t state;
    logic [CW-1:0]  baud;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;

    logic           sel_tx;
    logic           sel_ctrl;
    logic           push;
    logic           pop;
    logic           fifo_empty;
    logic [7:0]     fifo_rdata;
    logic [FCW-1:0] fifo_count;
    logic           unused_data;

    assign sel_tx   = i_io_write_en &&
                      (i_io_write_addr == BASE_ADDR + TXDATA_OFS);
    assign sel_ctrl = i_io_write_en &&
                      (i_io_write_addr == BASE_ADDR + CTRL_OFS);

    assign pop  = (state == IDLE) && !fifo_empty;
    assign push = sel_tx && (!o_fifo_full || pop);

    assign o_busy      = (state != IDLE) || (fifo_count != '0);
    assign unused_data = ^i_io_write_data[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .wdata (i_io_write_data[7:0]),
        .rdata (fifo_rdata),
        .full  (o_fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_overflow <= 1'b0;
        end else if (sel_tx && o_fifo_full && !pop) begin
            o_overflow <= 1'b1;
        end else if (sel_ctrl && i_io_write_data[0]) begin
            o_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            o_tx    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    o_tx <= 1'b1;
                    if (pop) begin
                        shreg <= fifo_rdata;
                        baud  <= BAUD_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    o_tx <= 1'b0;
                    if (baud == '0) begin
                        baud    <= BAUD_LOAD;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    o_tx <= shreg[0];
                    if (baud == '0) begin
                        baud <= BAUD_LOAD;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    o_tx <= 1'b1;
                    if (baud == '0) begin
                        state <= IDLE;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench: expected bytes queued at write time, frames decoded off o_tx.
// Framing, per-bit hold time, latency, overflow and reset behaviour are checked.
module tb_mmio_uart_tx;

    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] BASE       = 32'h1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        o_tx;
    logic        o_busy;
    logic        o_fifo_full;
    logic        o_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         got_ok[$];
    int         starts[$];
    int         got_idx = 0;

    int         cyc = 0;
    bit         mon_active = 1'b0;
    bit         prev_tx = 1'b1;
    bit         mon_ok;
    int         mon_cnt;
    int         slot;
    int         phase;
    logic [7:0] mon_byte;
    logic       mon_bit;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_io_write_addr (addr),
        .i_io_write_en   (we),
        .i_io_write_data (wdata),
        .o_tx            (o_tx),
        .o_busy          (o_busy),
        .o_fifo_full     (o_fifo_full),
        .o_overflow      (o_overflow)
    );

    always #5 clk = ~clk;

    // Frame decoder: samples o_tx once per cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            mon_active = 1'b0;
            prev_tx = 1'b1;
        end else begin
            if (!mon_active) begin
                if (prev_tx && !o_tx) begin
                    mon_active = 1'b1;
                    mon_cnt = 1;
                    mon_byte = '0;
                    mon_ok = 1'b1;
                    starts.push_back(cyc);
                end
            end else begin
                slot = mon_cnt / CLK_DIV;
                phase = mon_cnt % CLK_DIV;
                if (slot == 0) begin
                    if (o_tx !== 1'b0) mon_ok = 1'b0;
                end else if (slot <= 8) begin
                    if (phase == 0) begin
                        mon_bit = o_tx;
                        mon_byte[slot-1] = o_tx;
                    end else if (o_tx !== mon_bit) begin
                        mon_ok = 1'b0;
                    end
                end else if (o_tx !== 1'b1) begin
                    mon_ok = 1'b0;
                end
                mon_cnt++;
                if (mon_cnt == 10 * CLK_DIV) begin
                    mon_active = 1'b0;
                    got_q.push_back(mon_byte);
                    got_ok.push_back(mon_ok);
                end
            end
            prev_tx = o_tx;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        addr = '0;
        wdata = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        logic [7:0] e;
        n = 0;
        while ((o_busy || mon_active) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        tests_run++;
        if (o_busy || mon_active) begin
            tests_failed++;
            $display("FAIL %s_timeout: busy=%0b mon=%0b required idle",
                     name, o_busy, mon_active);
        end
        while (got_idx < got_q.size()) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL %s_extra_frame: got %02h, none expected",
                         name, got_q[got_idx]);
            end else begin
                e = exp_q.pop_front();
                if (got_q[got_idx] !== e || !got_ok[got_idx]) begin
                    tests_failed++;
                    $display("FAIL %s_frame: got %02h framing_ok=%0b, required %02h framing_ok=1",
                             name, got_q[got_idx], got_ok[got_idx], e);
                end
            end
            got_idx++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing: %0d frames outstanding, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_tx: got %b required 1", o_tx);
        end
        tests_run++;
        if ({o_busy, o_fifo_full, o_overflow} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/full/ovf got %b required 000",
                     {o_busy, o_fifo_full, o_overflow});
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        exp_q.push_back(8'h55);
        wr(BASE, 32'h0000_0055);
        tests_run++;
        if (o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat_busy: got %b required 1", o_busy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (o_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat_n1: tx got %b required 1", o_tx);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (o_tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_n2: tx got %b required 0", o_tx);
        end
        wait_idle("byte55");
        tests_run++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL after55: busy=%b tx=%b required busy=0 tx=1",
                     o_busy, o_tx);
        end
    endtask

    task automatic test_mask();
        exp_q.push_back(8'h41);
        wr(BASE, 32'hFFFF_FF41);
        wait_idle("mask41");
    endtask

    task automatic test_back_to_back();
        int base;
        base = starts.size();
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'(i));
            wr(BASE, 32'(i));
        end
        tests_run++;
        if (o_overflow !== 1'b1 || o_fifo_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ovf: ovf=%b full=%b required 1 1",
                     o_overflow, o_fifo_full);
        end
        wait_idle("b2b");
        tests_run++;
        if (starts.size() - base != 9) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d frames required 9",
                     starts.size() - base);
        end else begin
            for (int i = base + 1; i < base + 9; i++) begin
                tests_run++;
                if (starts[i] - starts[i-1] != 10 * CLK_DIV + 1) begin
                    tests_failed++;
                    $display("FAIL b2b_period: got %0d required %0d",
                             starts[i] - starts[i-1], 10 * CLK_DIV + 1);
                end
            end
        end
        tests_run++;
        if (o_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %b required 1", o_overflow);
        end
    endtask

    task automatic test_ctrl();
        wr(BASE + 32'd8, 32'h1);
        tests_run++;
        if (o_overflow !== 1'b1 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ctrl_other_addr: ovf=%b busy=%b required 1 0",
                     o_overflow, o_busy);
        end
        wr(BASE + 32'd4, 32'h2);
        tests_run++;
        if (o_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ctrl_bit1: ovf got %b required 1", o_overflow);
        end
        wr(BASE + 32'd4, 32'h1);
        tests_run++;
        if (o_overflow !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ctrl_clear: ovf=%b busy=%b required 0 0",
                     o_overflow, o_busy);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(8'h80 + 8'(i));
            wr(BASE, 32'h80 + 32'(i));
        end
        tests_run++;
        if (o_fifo_full !== 1'b1 || o_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill: full=%b ovf=%b required 1 0",
                     o_fifo_full, o_overflow);
        end
        // First pop at edge N+1; the next IDLE pop lands 41 edges later.
        repeat (33) @(negedge clk);
        exp_q.push_back(8'hC0);
        wr(BASE, 32'hC0);
        tests_run++;
        if (o_overflow !== 1'b0 || o_fifo_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pop: ovf=%b full=%b required 0 1",
                     o_overflow, o_fifo_full);
        end
        wait_idle("full_pop");
    endtask

    task automatic test_reset_mid();
        int frames_before;
        bit noisy;
        wr(BASE, 32'hA5);
        wr(BASE, 32'h3C);
        repeat (18) @(negedge clk);
        tests_run++;
        if (o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_busy: got %b required 1", o_busy);
        end
        frames_before = got_q.size();
        rstn = 1'b0;
        #1;
        tests_run++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_fifo_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_abort: tx=%b busy=%b full=%b required 1 0 0",
                     o_tx, o_busy, o_fifo_full);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        noisy = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (o_tx !== 1'b1 || o_busy !== 1'b0) noisy = 1'b1;
        end
        @(negedge clk);
        tests_run++;
        if (noisy || got_q.size() != frames_before) begin
            tests_failed++;
            $display("FAIL mid_quiet: activity=%0b frames=%0d required 0 %0d",
                     noisy, got_q.size(), frames_before);
        end
    endtask

    task automatic test_release_write();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_q.push_back(8'h3C);
        wr(BASE, 32'h3C);
        tests_run++;
        if (o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_write: busy got %b required 1", o_busy);
        end
        wait_idle("release");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_mask();
        test_back_to_back();
        test_ctrl();
        test_full_pop();
        test_reset_mid();
        test_release_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
